// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point FFT datapath (loader, sixtnpt wrapper, benches).
// No logic: compile-time values only.
// Not applicable: no handshake lives here.
package fft_pkg;

    localparam int FFT_WIDTH = 32;
    localparam int FFT_NPTS  = 16;
    localparam int FFT_IDX_W = 4;

    // LSB position of sample n inside a packed frame; sample 0 occupies the MSB slice.
    function automatic int slice_lsb(input int n);
        return FFT_WIDTH * (FFT_NPTS - 1 - n);
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of storage: NPTS complex words written one slice at a time, presented packed.
// Write lands on the clock edge; the packed view follows the stored words with no extra delay.
// No backpressure of its own; the owner decides when a write is allowed.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int NPTS  = FFT_NPTS,
    parameter int IDX_W = $clog2(NPTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WIDTH-1:0]        wr_re,
    input  logic [WIDTH-1:0]        wr_im,
    output logic [WIDTH*NPTS-1:0]   frame_re,
    output logic [WIDTH*NPTS-1:0]   frame_im
);

    logic [WIDTH-1:0] re_q [NPTS];
    logic [WIDTH-1:0] im_q [NPTS];
    logic [NPTS-1:0]  slice_en;

    // Decode the write index into one enable per slice.
    always_comb begin
        slice_en = '0;
        for (int n = 0; n < NPTS; n++) begin
            slice_en[n] = we && (idx == IDX_W'(n));
        end
    end

    // Slice storage; reset clears every word so a fresh bank reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NPTS; n++) begin
                re_q[n] <= '0;
                im_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NPTS; n++) begin
                if (slice_en[n]) begin
                    re_q[n] <= wr_re;
                    im_q[n] <= wr_im;
                end
            end
        end
    end

    // Sample 0 goes to the top slice, matching the {a,b,...,p} input order of sixtnpt.
    for (genvar n = 0; n < NPTS; n++) begin : g_pack
        assign frame_re[WIDTH*(NPTS-1-n) +: WIDTH] = re_q[n];
        assign frame_im[WIDTH*(NPTS-1-n) +: WIDTH] = im_q[n];
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Assembles NPTS streamed complex samples into a packed frame for sixtnpt, ping-pong buffered.
// m_valid rises one cycle after the last sample of a frame is accepted.
// s_ready drops only while the bank being written still holds an unconsumed frame; it comes from flags alone.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int WIDTH      = FFT_WIDTH,
    parameter int NPTS       = FFT_NPTS,
    parameter int LAST_CHECK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_re,
    input  logic [WIDTH-1:0]        s_im,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH*NPTS-1:0]   m_re,
    output logic [WIDTH*NPTS-1:0]   m_im,
    output logic                    frame_err
);

    localparam int               IDX_W    = $clog2(NPTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

    logic [IDX_W-1:0]       idx;
    logic                   wr_sel;
    logic                   rd_sel;
    logic [1:0]             full;
    logic [1:0]             full_nxt;
    logic                   err_q;

    logic                   accept;
    logic                   at_last;
    logic                   commit;
    logic                   drop;
    logic                   rel;
    logic                   framing_bad;

    logic [WIDTH*NPTS-1:0]  bank0_re;
    logic [WIDTH*NPTS-1:0]  bank0_im;
    logic [WIDTH*NPTS-1:0]  bank1_re;
    logic [WIDTH*NPTS-1:0]  bank1_im;

    assign s_ready   = !full[wr_sel];
    assign m_valid   = full[rd_sel];
    assign m_re      = rd_sel ? bank1_re : bank0_re;
    assign m_im      = rd_sel ? bank1_im : bank0_im;
    assign frame_err = err_q;

    // Handshake decode and next full flags; commit and release never hit the same bank,
    // because commit needs the write bank empty and release needs the read bank full.
    always_comb begin
        accept      = s_valid && s_ready;
        at_last     = (idx == LAST_IDX);
        commit      = accept && at_last;
        drop        = accept && (LAST_CHECK != 0) && s_last && !at_last;
        rel         = m_valid && m_ready;
        framing_bad = (LAST_CHECK != 0) && accept && (s_last != at_last);
        full_nxt    = full;
        if (commit) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rel) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    // Pointers, write index, full flags and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            full  <= full_nxt;
            err_q <= framing_bad;
            if (commit) begin
                wr_sel <= ~wr_sel;
            end
            if (rel) begin
                rd_sel <= ~rd_sel;
            end
            // A dropped partial frame restarts at slice 0; its stale words are overwritten before the next commit.
            if (commit || drop) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
        end
    end

    fft_frame_bank #(
        .WIDTH (WIDTH),
        .NPTS  (NPTS),
        .IDX_W (IDX_W)
    ) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .we       (accept && !wr_sel),
        .idx      (idx),
        .wr_re    (s_re),
        .wr_im    (s_im),
        .frame_re (bank0_re),
        .frame_im (bank0_im)
    );

    fft_frame_bank #(
        .WIDTH (WIDTH),
        .NPTS  (NPTS),
        .IDX_W (IDX_W)
    ) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .we       (accept && wr_sel),
        .idx      (idx),
        .wr_re    (s_re),
        .wr_im    (s_im),
        .frame_re (bank1_re),
        .frame_im (bank1_im)
    );

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: reset, packing, backpressure, concurrent commit/release, framing, mid-op reset.
// Outputs are sampled 1 time unit after each rising edge.
// m_ready is driven explicitly by each step.
module tb_fft_frame_loader;

    localparam int         W   = 32;
    localparam int         N   = 16;
    localparam int         FW  = W * N;
    localparam logic [W-1:0] IMO = 32'hA000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_re;
    logic [W-1:0]  s_im;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [FW-1:0] m_re;
    logic [FW-1:0] m_im;
    logic          frame_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fft_frame_loader #(
        .WIDTH      (W),
        .NPTS       (N),
        .LAST_CHECK (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_re      (m_re),
        .m_im      (m_im),
        .frame_err (frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame whose sample n holds base+n, sample 0 in the top 32 bits.
    function automatic logic [FW-1:0] frame(input logic [W-1:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int n = 0; n < N; n++) begin
            f[FW-1-W*n -: W] = base + W'(n);
        end
        return f;
    endfunction

    // Present one sample and hold it until it is accepted (bounded).
    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        while (!s_ready && waited < 64) begin
            tick();
            waited++;
        end
        tests++;
        assert (waited < 64) else begin
            fails++;
            $error("FAIL send_timeout observed=%0d expected<64", waited);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] base);
        for (int n = 0; n < N; n++) begin
            send(base + W'(n), base + IMO + W'(n), n == N - 1);
        end
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] exp_single;

        rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; m_ready = 1'b0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_s_ready", FW'(s_ready), FW'(1));
        chk("rst_m_valid", FW'(m_valid), FW'(0));
        chk("rst_m_re", m_re, '0);
        chk("rst_m_im", m_im, '0);
        chk("rst_frame_err", FW'(frame_err), FW'(0));

        // Single frame packing
        for (int n = 0; n < N; n++) begin
            logic [W-1:0] v;
            v = (n == 0) ? 32'h0011_0000 : (n == 1) ? 32'h1000_0000 : 32'h0;
            send(v, 32'h0, n == N - 1);
            if (n == N - 2) chk("single_no_valid_early", FW'(m_valid), FW'(0));
        end
        exp_single = {32'h0011_0000, 32'h1000_0000, 448'h0};
        chk("single_m_valid", FW'(m_valid), FW'(1));
        chk("single_m_re", m_re, exp_single);
        chk("single_m_im", m_im, '0);
        chk("single_frame_err", FW'(frame_err), FW'(0));
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("single_released", FW'(m_valid), FW'(0));

        // Backpressure: two frames fill both banks
        for (int i = 0; i < 2 * N; i++) begin
            send(W'(i), IMO + W'(i), (i % N) == N - 1);
        end
        chk("bp_ready_low", FW'(s_ready), FW'(0));
        chk("bp_valid", FW'(m_valid), FW'(1));
        chk("bp_f0_re", m_re, frame(32'd0));
        chk("bp_f0_im", m_im, frame(IMO));
        s_valid = 1'b1; s_re = 32'd32; s_im = IMO + 32'd32; s_last = 1'b0;
        tick(); tick();
        chk("bp_ready_held", FW'(s_ready), FW'(0));
        chk("bp_f0_stable", m_re, frame(32'd0));
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("bp_ready_back", FW'(s_ready), FW'(1));
        chk("bp_f1_re", m_re, frame(32'd16));
        chk("bp_f1_im", m_im, frame(IMO + 32'd16));
        for (int i = 2 * N; i < 3 * N; i++) begin
            send(W'(i), IMO + W'(i), (i % N) == N - 1);
        end
        chk("bp_full_again", FW'(s_ready), FW'(0));
        chk("bp_f1_still", m_re, frame(32'd16));
        m_ready = 1'b1; tick();
        chk("bp_f2_re", m_re, frame(32'd32));
        chk("bp_f2_im", m_im, frame(IMO + 32'd32));
        tick(); m_ready = 1'b0;
        chk("bp_drained", FW'(m_valid), FW'(0));

        // Concurrent commit and release
        send_frame(32'h100);
        for (int n = 0; n < N - 1; n++) begin
            send(32'h200 + W'(n), 32'h200 + IMO + W'(n), 1'b0);
        end
        chk("cc_pre_valid", FW'(m_valid), FW'(1));
        chk("cc_pre_re", m_re, frame(32'h100));
        m_ready = 1'b1;
        send(32'h20F, 32'h20F + IMO, 1'b1);
        m_ready = 1'b0;
        chk("cc_valid", FW'(m_valid), FW'(1));
        chk("cc_re", m_re, frame(32'h200));
        chk("cc_im", m_im, frame(32'h200 + IMO));
        chk("cc_ready", FW'(s_ready), FW'(1));
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("cc_drained", FW'(m_valid), FW'(0));

        // Framing error: early s_last drops the partial frame
        for (int n = 0; n < 6; n++) begin
            send(32'h300 + W'(n), 32'h300 + IMO + W'(n), n == 5);
        end
        chk("early_err_pulse", FW'(frame_err), FW'(1));
        chk("early_no_valid", FW'(m_valid), FW'(0));
        tick();
        chk("early_err_cleared", FW'(frame_err), FW'(0));
        send_frame(32'h400);
        chk("early_next_err", FW'(frame_err), FW'(0));
        chk("early_next_valid", FW'(m_valid), FW'(1));
        chk("early_next_re", m_re, frame(32'h400));
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        // Framing error: missing s_last still commits
        for (int n = 0; n < N; n++) begin
            send(32'h500 + W'(n), 32'h500 + IMO + W'(n), 1'b0);
        end
        chk("nolast_valid", FW'(m_valid), FW'(1));
        chk("nolast_err", FW'(frame_err), FW'(1));
        chk("nolast_re", m_re, frame(32'h500));
        tick();
        chk("nolast_err_cleared", FW'(frame_err), FW'(0));
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        // Reset with one bank full and a partial frame in the other
        send_frame(32'h600);
        for (int n = 0; n < 7; n++) begin
            send(32'h700 + W'(n), 32'h700 + IMO + W'(n), 1'b0);
        end
        chk("mid_pre_valid", FW'(m_valid), FW'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_m_valid", FW'(m_valid), FW'(0));
        chk("mid_s_ready", FW'(s_ready), FW'(1));
        chk("mid_m_re", m_re, '0);
        chk("mid_m_im", m_im, '0);
        chk("mid_frame_err", FW'(frame_err), FW'(0));
        send_frame(32'h800);
        chk("mid_fresh_valid", FW'(m_valid), FW'(1));
        chk("mid_fresh_re", m_re, frame(32'h800));
        chk("mid_fresh_im", m_im, frame(32'h800 + IMO));
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("mid_fresh_drained", FW'(m_valid), FW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
